// File: rtl/audio_clip_player.sv
// Voice-prompt clip player: fetches CLIP_LEN samples from a 1-cycle-latency ROM at
// one sample per SAMPLE_DIV clocks and drives a PWM pin. Optional AUDIO_END_MARKER_EN.
module audio_clip_player #(
  parameter int ADDR_W     = 17,
  parameter int CLIP_LEN   = 4096,
  parameter int SAMPLE_DIV = 6250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_audio,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        rom_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              pwm_out,
  output logic              busy,
  output logic              done
);

  localparam int OFF_W = (CLIP_LEN > 1) ? $clog2(CLIP_LEN) : 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(CLIP_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_CAP  = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;

  state_t            state_q, state_d;
  logic              play_prev_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [7:0]        sample_q, sample_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              pwm_out_q, pwm_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trigger;

  assign trigger = play_audio & ~play_prev_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    offset_d  = offset_q;
    div_cnt_d = div_cnt_q;
    sample_d  = sample_q;
    pwm_cnt_d = pwm_cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          base_d    = mem_addr;
          offset_d  = '0;
          div_cnt_d = '0;
          sample_d  = '0;
          state_d   = PLAY;
        end
      end
      PLAY: begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_CAP) sample_d = rom_data;
        if (div_cnt_q == DIV_LAST) begin
          if (offset_q == OFF_LAST) state_d = FINISH;
          else                      offset_d = offset_q + 1'b1;
        end
`ifdef AUDIO_END_MARKER_EN
        // A zero byte terminates the clip; nothing further is fetched.
        if (div_cnt_q == DIV_CAP && rom_data == 8'h00) begin
          sample_d = '0;
          state_d  = FINISH;
        end
`endif
      end
      FINISH: begin
        sample_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so the registered copies line up
    // with the cycle in which div_cnt/state actually hold those values.
    rom_en_d   = (state_d == PLAY) && (div_cnt_d == '0);
    rom_addr_d = rom_en_d ? base_d + ADDR_W'(offset_d) : rom_addr_q;
    busy_d     = (state_d == PLAY);
    done_d     = (state_d == FINISH);
    pwm_out_d  = busy_d && (pwm_cnt_d < sample_d);
  end

  // The play edge detector keeps sampling through reset so a level held across
  // reset release is not mistaken for a fresh request.
  always_ff @(posedge clk) begin
    play_prev_q <= play_audio;
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      offset_q   <= '0;
      div_cnt_q  <= '0;
      sample_q   <= '0;
      pwm_cnt_q  <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      pwm_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      div_cnt_q  <= div_cnt_d;
      sample_q   <= sample_d;
      pwm_cnt_q  <= pwm_cnt_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      pwm_out_q  <= pwm_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign pwm_out  = pwm_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/audio_clip_player.md
Name: audio_clip_player

Overview:
- Playback stage directly downstream of the microwave voice-prompt selector.
- Consumes the selector's clip base address and play request, streams 8-bit samples from the voice ROM at a fixed sample rate, and drives a PWM audio pin.
- Sits between the prompt selector and the board speaker filter; the ROM is an external synchronous block with 1-cycle read latency.

Parameters:
- ADDR_W, 17, width of the ROM address and the clip base address.
- CLIP_LEN, 4096, samples per clip; clips are spaced 0x1000 apart.
- SAMPLE_DIV, 6250, clocks per sample (50 MHz / 8 kHz); must be at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- play_audio  input  1  play request level from the prompt selector
- mem_addr  input  ADDR_W  clip base address from the prompt selector; sampled only at trigger
- rom_data  input  8  ROM read data, valid 1 cycle after rom_en
- rom_en  output  1  ROM read strobe
- rom_addr  output  ADDR_W  ROM read address
- pwm_out  output  1  PWM audio output
- busy  output  1  high while a clip is playing
- done  output  1  single-cycle pulse when a clip completes

Behaviour:
- Reset values:
  - All outputs are 0.
  - state=IDLE, play_d=0, base=0, offset=0, div_cnt=0, sample_reg=0, pwm_cnt=0.
- Trigger: rising edge of play_audio, i.e. play_audio=1 and play_d=0, where play_d is play_audio registered every cycle including during reset.
- States: IDLE, PLAY, FINISH.
- IDLE:
  - On trigger: base<=mem_addr, offset<=0, div_cnt<=0, sample_reg<=0, go to PLAY.
  - busy rises the cycle after the trigger.
- PLAY (busy=1):
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - div_cnt==0: rom_en=1 and rom_addr=base+offset, both registered so they appear the same cycle div_cnt reads 0.
  - Address sum is ADDR_W bits and wraps modulo 2^ADDR_W.
  - rom_en is low in every other cycle.
  - div_cnt==1: sample_reg<=rom_data.
  - div_cnt==SAMPLE_DIV-1 and offset==CLIP_LEN-1: go to FINISH.
  - div_cnt==SAMPLE_DIV-1 otherwise: offset<=offset+1.
- FINISH:
  - done=1 for exactly one cycle, busy=0, sample_reg<=0, go to IDLE.
- Triggers while in PLAY or FINISH are ignored and are not queued.
- Re-trigger needs play_audio to be seen low and then high again.
- play_audio falling mid-clip does not abort the clip; it plays to completion.
- mem_addr changes after the trigger have no effect.
- PWM:
  - pwm_cnt is an 8-bit free-running counter that wraps 255 to 0.
  - pwm_out = busy && (pwm_cnt < sample_reg), registered.
  - sample 0 gives a constant low; sample 255 gives high 255 of every 256 cycles.
  - pwm_out is 0 whenever busy=0.
- Reset asserted mid-clip returns every state variable to its reset value on the next edge; no done pulse is issued.
- Total busy duration per full clip = CLIP_LEN*SAMPLE_DIV cycles.

Optional Feature:
- Macro: AUDIO_END_MARKER_EN.
- Defined:
  - A sample byte equal to 8'h00, captured at div_cnt==1, ends the clip early.
  - sample_reg is forced to 0, state goes to FINISH on the next cycle, and done pulses once.
  - Remaining samples are not fetched.
- Undefined:
  - 8'h00 is an ordinary silent sample.
  - Clips always run CLIP_LEN samples.

Test Plan:
- Bench parameters: SAMPLE_DIV=4, CLIP_LEN=8.
1. Basic clip: mem_addr=17'h3000, play_audio 0->1.
   - rom_en pulses every 4 cycles with rom_addr 0x3000..0x3007.
   - busy high 32 cycles; done pulses once at the end; pwm_out=0 after.
2. PWM duty: ROM returns 8'h40 for every address.
   - Over 256 busy cycles pwm_out is high for 64 cycles (pwm_cnt 0..63).
   - With 8'hFF: high 255 of 256.
3. Retrigger ignored:
   - Start clip 0x1000; mid-clip drop play_audio, set mem_addr=0x2000, raise play_audio.
   - Required: addresses stay 0x1000..0x1007 and exactly one done.
   - A new edge after done starts clip 0x2000.
4. Address wrap: mem_addr=17'h1FFFC.
   - rom_addr sequence is 1FFFC, 1FFFD, 1FFFE, 1FFFF, 00000, 00001, 00002, 00003.
5. Reset mid-clip: assert rst at the 3rd sample.
   - Next cycle busy=0, rom_en=0, pwm_out=0; no done pulse.
   - After rst release with play_audio held high, no playback occurs until play_audio toggles low then high.
6. With AUDIO_END_MARKER_EN defined: ROM returns 0x55, 0x55, 0x00, ... from base 0x4000.
   - Exactly 3 rom_en pulses (0x4000-0x4002), then done.
   - busy lasts 10 cycles.
